// File: rtl/dps_decoder_37_if.sv
// Receive-side bus bundle for the 37-wire DPS decoder.
// Master drives codewords and the counter clear; slave returns decoded words.
interface dps_decoder_37_if #(
    parameter int DW = 26
);
    logic          code_valid;
    logic [36:0]   codein;
    logic          err_clr;
    logic          data_valid;
    logic [DW-1:0] dataout;
    logic          overflow;
    logic [15:0]   err_cnt;

    modport master (
        output code_valid,
        output codein,
        output err_clr,
        input  data_valid,
        input  dataout,
        input  overflow,
        input  err_cnt
    );

    modport slave (
        input  code_valid,
        input  codein,
        input  err_clr,
        output data_valid,
        output dataout,
        output overflow,
        output err_cnt
    );
endinterface

// File: rtl/dps_decoder_37.sv
// Three-stage DPS (Fibonacci weight-sum) codeword decoder for a 37-wire bus,
// with overflow flag and saturating overflow counter.
module dps_decoder_37 (
    input logic             clock,
    input logic             rst_n,
    dps_decoder_37_if.slave bus
);
    localparam int DBLEN37 = 26;
    localparam int SW      = DBLEN37 + 2;

    // FNS(1)=1, FNS(2)=2, FNS(n)=FNS(n-1)+FNS(n-2)
    function automatic logic [63:0] fns(input int n);
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] c;
        a = 64'd1;
        b = 64'd2;
        if (n <= 1) return 64'd1;
        for (int i = 3; i <= n; i++) begin
            c = a + b;
            a = b;
            b = c;
        end
        return b;
    endfunction

    function automatic logic [63:0] wt(input int k);
        logic [63:0] w;
        if (k == 0)       w = 64'd1;
        else if (k <= 34) w = fns(k + 1);
        else if (k == 35) w = fns(36) << 1;
        else              w = fns(37);
        return w;
    endfunction

    function automatic logic [63:0] gsum(input int lo, input int hi);
        logic [63:0] s;
        s = 64'd0;
        for (int k = lo; k <= hi; k++) s = s + wt(k);
        return s;
    endfunction

    localparam int PW0 = $clog2(gsum(0, 9) + 64'd1);
    localparam int PW1 = $clog2(gsum(10, 19) + 64'd1);
    localparam int PW2 = $clog2(gsum(20, 29) + 64'd1);
    localparam int PW3 = $clog2(gsum(30, 36) + 64'd1);

    logic [36:0]        r_code;
    logic               r_v0;
    logic [PW0-1:0]     r_ps0;
    logic [PW1-1:0]     r_ps1;
    logic [PW2-1:0]     r_ps2;
    logic [PW3-1:0]     r_ps3;
    logic               r_v1;
    logic               r_dv;
    logic [DBLEN37-1:0] r_dout;
    logic               r_ovf;
    logic [15:0]        r_err;

    logic [SW-1:0]      w_term [37];
    logic [PW0-1:0]     w_ps0;
    logic [PW1-1:0]     w_ps1;
    logic [PW2-1:0]     w_ps2;
    logic [PW3-1:0]     w_ps3;
    logic [SW-1:0]      w_sum;
    logic               w_ovf;
    logic               w_inc;

    for (genvar k = 0; k < 37; k++) begin : g_term
        localparam logic [63:0] WK = wt(k);
        assign w_term[k] = r_code[k] ? WK[SW-1:0] : '0;
    end

    always_comb begin
        w_ps0 = '0;
        w_ps1 = '0;
        w_ps2 = '0;
        w_ps3 = '0;
        for (int k = 0; k < 10; k++)
            w_ps0 = w_ps0 + PW0'(w_term[k]);
        for (int k = 10; k < 20; k++)
            w_ps1 = w_ps1 + PW1'(w_term[k]);
        for (int k = 20; k < 30; k++)
            w_ps2 = w_ps2 + PW2'(w_term[k]);
        for (int k = 30; k < 37; k++)
            w_ps3 = w_ps3 + PW3'(w_term[k]);
    end

    assign w_sum = SW'(r_ps0) + SW'(r_ps1)
                 + SW'(r_ps2) + SW'(r_ps3);
    assign w_ovf = |w_sum[SW-1:DBLEN37];
    assign w_inc = r_v1 && w_ovf && (r_err != 16'hFFFF);

    // S0: capture
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_code <= '0;
            r_v0   <= 1'b0;
        end else begin
            r_code <= bus.codein;
            r_v0   <= bus.code_valid;
        end
    end

    // S1: partial sums
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_ps0 <= '0;
            r_ps1 <= '0;
            r_ps2 <= '0;
            r_ps3 <= '0;
            r_v1  <= 1'b0;
        end else begin
            r_ps0 <= w_ps0;
            r_ps1 <= w_ps1;
            r_ps2 <= w_ps2;
            r_ps3 <= w_ps3;
            r_v1  <= r_v0;
        end
    end

    // S2: outputs hold while no valid result arrives
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_dv   <= 1'b0;
            r_dout <= '0;
            r_ovf  <= 1'b0;
        end else begin
            r_dv <= r_v1;
            if (r_v1) begin
                r_dout <= w_sum[DBLEN37-1:0];
                r_ovf  <= w_ovf;
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n)
            r_err <= '0;
        else if (bus.err_clr)
            r_err <= '0;
        else if (w_inc)
            r_err <= r_err + 16'd1;
    end

    assign bus.data_valid = r_dv;
    assign bus.dataout    = r_dout;
    assign bus.overflow   = r_ovf;
    assign bus.err_cnt    = r_err;
endmodule
